// File: rtl/reg_wb_queue_if.sv
// Bundle between the writeback producers, the register file write port and the
// read-stage bypass lookup. The queue connects through the slave modport; the
// producer/consumer side (or a testbench) uses the master modport.
interface reg_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          MEM_valid;
  logic [AW-1:0] MEM_addr;
  logic [DW-1:0] MEM_data;
  logic          ALU_valid;
  logic [AW-1:0] ALU_addr;
  logic [DW-1:0] ALU_data;
  logic          WB_ready;
  logic          REG_write_1;
  logic [AW-1:0] REG_address_wr;
  logic [DW-1:0] REG_data_wb_in1;
  logic [AW-1:0] LK_addr_1;
  logic [AW-1:0] LK_addr_2;
  logic          LK_hit_1;
  logic          LK_hit_2;
  logic [DW-1:0] LK_data_1;
  logic [DW-1:0] LK_data_2;
  logic          WB_overflow;
  logic [CW-1:0] WB_count;

  modport slave (
    input  MEM_valid, MEM_addr, MEM_data,
    input  ALU_valid, ALU_addr, ALU_data,
    input  LK_addr_1, LK_addr_2,
    output WB_ready, REG_write_1, REG_address_wr, REG_data_wb_in1,
    output LK_hit_1, LK_hit_2, LK_data_1, LK_data_2,
    output WB_overflow, WB_count
  );

  modport master (
    output MEM_valid, MEM_addr, MEM_data,
    output ALU_valid, ALU_addr, ALU_data,
    output LK_addr_1, LK_addr_2,
    input  WB_ready, REG_write_1, REG_address_wr, REG_data_wb_in1,
    input  LK_hit_1, LK_hit_2, LK_data_1, LK_data_2,
    input  WB_overflow, WB_count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the 32x32 register file: accepts up to two
// requests per cycle (MEM older than ALU), drains one per cycle into a
// registered write port, and offers a youngest-first pending-write lookup.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           rst,
  reg_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // queue storage and pointers
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // output stage and sticky error
  logic          out_we_q, out_we_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          ovf_q, ovf_d;

  // combinational helpers
  logic          ready_s;
  logic          push_mem_s;
  logic          push_alu_s;
  logic          pop_s;
  logic [PW-1:0] alu_idx_s;
  logic          m1_s, m2_s;
  logic          hit1_s, hit2_s;
  logic [DW-1:0] lkd1_s, lkd2_s;

  // Next-state: admission, push into tail slots, pop head into output stage
  always_comb begin
    // Ready looks only at current occupancy so two pushes always fit.
    ready_s    = (count_q <= CW'(DEPTH - 2));
    push_mem_s = ready_s && bus.MEM_valid && (bus.MEM_addr != {AW{1'b0}});
    push_alu_s = ready_s && bus.ALU_valid && (bus.ALU_addr != {AW{1'b0}});
    pop_s      = (count_q != {CW{1'b0}});
    ovf_d      = ovf_q | (~ready_s & (bus.MEM_valid | bus.ALU_valid));

    addr_d = addr_q;
    data_d = data_q;
    // MEM is older in program order, so it takes the first free slot.
    addr_d[tail_q] = push_mem_s ? bus.MEM_addr : addr_q[tail_q];
    data_d[tail_q] = push_mem_s ? bus.MEM_data : data_q[tail_q];
    alu_idx_s      = tail_q + PW'(push_mem_s);
    addr_d[alu_idx_s] = push_alu_s ? bus.ALU_addr : addr_d[alu_idx_s];
    data_d[alu_idx_s] = push_alu_s ? bus.ALU_data : data_d[alu_idx_s];

    tail_d  = tail_q + PW'(push_mem_s) + PW'(push_alu_s);
    head_d  = head_q + PW'(pop_s);
    count_d = count_q + CW'(push_mem_s) + CW'(push_alu_s) - CW'(pop_s);

    // Address/data hold their last value when nothing drains.
    out_we_d   = pop_s;
    out_addr_d = pop_s ? addr_q[head_q] : out_addr_q;
    out_data_d = pop_s ? data_q[head_q] : out_data_q;
  end

  // Control and output-stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      out_we_q   <= 1'b0;
      out_addr_q <= {AW{1'b0}};
      out_data_q <= {DW{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Queue payload storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Bypass lookup: output stage first, then queue oldest to youngest so the
  // youngest match overwrites older ones
  always_comb begin
    m1_s   = out_we_q && (bus.LK_addr_1 != {AW{1'b0}}) && (out_addr_q == bus.LK_addr_1);
    m2_s   = out_we_q && (bus.LK_addr_2 != {AW{1'b0}}) && (out_addr_q == bus.LK_addr_2);
    hit1_s = m1_s;
    hit2_s = m2_s;
    lkd1_s = m1_s ? out_data_q : {DW{1'b0}};
    lkd2_s = m2_s ? out_data_q : {DW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      m1_s   = (CW'(k) < count_q) && (bus.LK_addr_1 != {AW{1'b0}}) &&
               (addr_q[head_q + PW'(k)] == bus.LK_addr_1);
      m2_s   = (CW'(k) < count_q) && (bus.LK_addr_2 != {AW{1'b0}}) &&
               (addr_q[head_q + PW'(k)] == bus.LK_addr_2);
      hit1_s = hit1_s | m1_s;
      hit2_s = hit2_s | m2_s;
      lkd1_s = m1_s ? data_q[head_q + PW'(k)] : lkd1_s;
      lkd2_s = m2_s ? data_q[head_q + PW'(k)] : lkd2_s;
    end
  end

  assign bus.WB_ready        = ready_s;
  assign bus.REG_write_1     = out_we_q;
  assign bus.REG_address_wr  = out_addr_q;
  assign bus.REG_data_wb_in1 = out_data_q;
  assign bus.LK_hit_1        = hit1_s;
  assign bus.LK_hit_2        = hit2_s;
  assign bus.LK_data_1       = lkd1_s;
  assign bus.LK_data_2       = lkd2_s;
  assign bus.WB_overflow     = ovf_q;
  assign bus.WB_count        = count_q;
endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bif ();

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // reference model state
  ent_t          mq[$];
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic          m_ovf = 1'b0;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // youngest pending write to a, searched newest-first, then the output stage
  function automatic logic [DW:0] mlook(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_we && m_wa == a) return {1'b1, m_wd};
    return '0;
  endfunction

  // model update on each rising edge from the inputs sampled at that edge
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_ovf = 1'b0;
    end else begin
      bit   rdy;
      ent_t h;
      rdy = (DEPTH - mq.size()) >= 2;
      if (mq.size() > 0) begin
        h = mq.pop_front();
        m_we = 1'b1; m_wa = h.a; m_wd = h.d;
      end else begin
        m_we = 1'b0;
      end
      if (rdy) begin
        if (bif.MEM_valid && bif.MEM_addr != '0) mq.push_back(ent_t'({bif.MEM_addr, bif.MEM_data}));
        if (bif.ALU_valid && bif.ALU_addr != '0) mq.push_back(ent_t'({bif.ALU_addr, bif.ALU_data}));
      end else if (bif.MEM_valid || bif.ALU_valid) begin
        m_ovf = 1'b1;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW:0] e1, e2;
      e1 = mlook(bif.LK_addr_1);
      e2 = mlook(bif.LK_addr_2);
      check("ready", 64'(bif.WB_ready),        64'((DEPTH - mq.size()) >= 2));
      check("count", 64'(bif.WB_count),        64'(mq.size()));
      check("we",    64'(bif.REG_write_1),     64'(m_we));
      check("waddr", 64'(bif.REG_address_wr),  64'(m_wa));
      check("wdata", 64'(bif.REG_data_wb_in1), 64'(m_wd));
      check("ovf",   64'(bif.WB_overflow),     64'(m_ovf));
      check("hit1",  64'(bif.LK_hit_1),        64'(e1[DW]));
      check("data1", 64'(bif.LK_data_1),       64'(e1[DW-1:0]));
      check("hit2",  64'(bif.LK_hit_2),        64'(e2[DW]));
      check("data2", 64'(bif.LK_data_2),       64'(e2[DW-1:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bif.MEM_valid = 1'b0;
    bif.ALU_valid = 1'b0;
  endtask

  task automatic mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.MEM_valid = 1'b1; bif.MEM_addr = a; bif.MEM_data = d;
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.ALU_valid = 1'b1; bif.ALU_addr = a; bif.ALU_data = d;
  endtask

  initial begin
    bif.MEM_valid = 1'b0; bif.MEM_addr = '0; bif.MEM_data = '0;
    bif.ALU_valid = 1'b0; bif.ALU_addr = '0; bif.ALU_data = '0;
    bif.LK_addr_1 = 5'd5; bif.LK_addr_2 = 5'd7;

    // reset then idle
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("idle_we",    64'(bif.REG_write_1), 64'd0);
    check("idle_count", 64'(bif.WB_count),    64'd0);
    check("idle_ready", 64'(bif.WB_ready),    64'd1);
    check("idle_hit1",  64'(bif.LK_hit_1),    64'd0);
    check("idle_hit2",  64'(bif.LK_hit_2),    64'd0);

    // single ALU write
    alu(5'd5, 32'hDEADBEEF);
    tick(); idle();
    check("single_count1", 64'(bif.WB_count), 64'd1);
    tick();
    check("single_we",    64'(bif.REG_write_1),     64'd1);
    check("single_addr",  64'(bif.REG_address_wr),  64'd5);
    check("single_data",  64'(bif.REG_data_wb_in1), 64'hDEADBEEF);
    check("single_count0", 64'(bif.WB_count),       64'd0);
    tick();
    check("single_we_off", 64'(bif.REG_write_1), 64'd0);

    // dual push ordering
    mem(5'd3, 32'h11); alu(5'd4, 32'h22);
    tick(); idle();
    check("dual_count2", 64'(bif.WB_count), 64'd2);
    tick();
    check("dual_addr_a", 64'(bif.REG_address_wr),  64'd3);
    check("dual_data_a", 64'(bif.REG_data_wb_in1), 64'h11);
    check("dual_count1", 64'(bif.WB_count),        64'd1);
    tick();
    check("dual_addr_b", 64'(bif.REG_address_wr),  64'd4);
    check("dual_data_b", 64'(bif.REG_data_wb_in1), 64'h22);
    check("dual_count0", 64'(bif.WB_count),        64'd0);
    tick();

    // bypass: youngest wins, zero address never hits
    alu(5'd7, 32'hA);
    tick();
    alu(5'd7, 32'hB);
    tick(); idle();
    bif.LK_addr_1 = 5'd7; bif.LK_addr_2 = 5'd0;
    #1;
    check("byp_hit1",  64'(bif.LK_hit_1),  64'd1);
    check("byp_data1", 64'(bif.LK_data_1), 64'hB);
    check("byp_hit2",  64'(bif.LK_hit_2),  64'd0);
    tick();
    check("byp_out_hit1", 64'(bif.LK_hit_1), 64'd1);
    tick();
    check("byp_drained_hit1", 64'(bif.LK_hit_1), 64'd0);

    // full / overflow
    mem(5'd1, 32'h101); alu(5'd2, 32'h102);
    tick();
    check("full_count2", 64'(bif.WB_count), 64'd2);
    check("full_ready2", 64'(bif.WB_ready), 64'd1);
    mem(5'd8, 32'h108); alu(5'd9, 32'h109);
    tick();
    check("full_count3", 64'(bif.WB_count),    64'd3);
    check("full_ready3", 64'(bif.WB_ready),    64'd0);
    check("full_ovf0",   64'(bif.WB_overflow), 64'd0);
    mem(5'd12, 32'h10C); alu(5'd13, 32'h10D);
    tick(); idle();
    check("full_drop_count", 64'(bif.WB_count),       64'd2);
    check("full_ovf1",       64'(bif.WB_overflow),    64'd1);
    check("full_out_addr",   64'(bif.REG_address_wr), 64'd2);
    repeat (4) tick();
    check("full_ovf_sticky", 64'(bif.WB_overflow), 64'd1);

    // zero register and reset mid-drain
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu(5'd0, 32'h55);
    tick(); idle();
    check("zero_count", 64'(bif.WB_count),    64'd0);
    check("zero_ovf",   64'(bif.WB_overflow), 64'd0);
    check("zero_we",    64'(bif.REG_write_1), 64'd0);
    mem(5'd10, 32'h1A); alu(5'd11, 32'h1B);
    tick(); idle();
    check("mid_count2", 64'(bif.WB_count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 64'(bif.WB_count),    64'd0);
    check("mid_rst_we",    64'(bif.REG_write_1), 64'd0);
    tick();
    check("mid_after_we1", 64'(bif.REG_write_1), 64'd0);
    tick();
    check("mid_after_we2", 64'(bif.REG_write_1), 64'd0);

    // randomized traffic with small address range to force hits and zeros
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(63, 0) == 0);
      bif.MEM_valid = 1'($urandom_range(1, 0));
      bif.MEM_addr  = 5'($urandom_range(7, 0));
      bif.MEM_data  = $urandom;
      bif.ALU_valid = 1'($urandom_range(1, 0));
      bif.ALU_addr  = 5'($urandom_range(7, 0));
      bif.ALU_data  = $urandom;
      bif.LK_addr_1 = 5'($urandom_range(7, 0));
      bif.LK_addr_2 = 5'($urandom_range(7, 0));
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Writer-side front end for the 32x32 register file. It collects writeback requests from the ALU and load paths and buffers them in a small in-order queue.
- It drains one request per cycle into the register file's single write port: write enable, write address and write data.
- It also provides a pending-write lookup, so the read stage can detect and bypass values that have not yet reached the register file.

Parameters:
DEPTH, 4, queue entries (power of two, >= 2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
MEM_valid  in  1  load-path writeback request
MEM_addr  in  AW  load destination register
MEM_data  in  DW  load result
ALU_valid  in  1  ALU-path writeback request
ALU_addr  in  AW  ALU destination register
ALU_data  in  DW  ALU result
WB_ready  out  1  producers may assert valid this cycle
REG_write_1  out  1  register file write enable (registered)
REG_address_wr  out  AW  register file write address (registered)
REG_data_wb_in1  out  DW  register file write data (registered)
LK_addr_1  in  AW  lookup address, read port 1
LK_addr_2  in  AW  lookup address, read port 2
LK_hit_1  out  1  pending write exists for LK_addr_1 (combinational)
LK_hit_2  out  1  pending write exists for LK_addr_2 (combinational)
LK_data_1  out  DW  youngest pending data for LK_addr_1; 0 when no hit
LK_data_2  out  DW  youngest pending data for LK_addr_2; 0 when no hit
WB_overflow  out  1  sticky error: a request arrived while WB_ready=0
WB_count  out  3  current queue occupancy (0..DEPTH)

Behaviour:
- Reset (rst=1 at a rising edge):
  - Queue empties: count=0, head=tail=0.
  - REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, WB_overflow=0.
  - An in-flight output-stage write is discarded.
- WB_ready = (DEPTH - count >= 2). It depends on the current count only; a pop in the same cycle is not credited.
- Enqueue, when WB_ready=1:
  - Each valid request with a nonzero addr is pushed.
  - If MEM and ALU are valid in the same cycle, MEM is pushed first (older in program order), then ALU.
  - Requests with addr=0 are dropped silently: no push, no overflow.
- Enqueue, when WB_ready=0: any valid request is dropped and WB_overflow is set to 1 until reset.
- Drain, every cycle:
  - If count>0 at the edge: head entry moves to the output regs, REG_write_1<=1, head advances.
  - If count=0: REG_write_1<=0; address and data regs hold their previous values.
- Latency:
  - A request sampled at edge N reaches the output regs at edge N+1 at the earliest.
  - The register file commits it at edge N+2.
- Occupancy: count_next = count + pushes(0..2) - pop(0/1). Push and pop in the same cycle are legal. Pointers wrap modulo DEPTH.
- Lookup, for each port independently:
  - Candidates are all valid queue entries plus the output stage when REG_write_1=1.
  - LK_hit is set when LK_addr != 0 and any candidate address matches.
  - Priority, youngest first: queue tail-1 down to head, then the output stage.
  - LK_addr=0 always gives hit=0, data=0.
  - Requests entering in the current cycle are not visible to lookup.
- Ordering: writes reach the register file strictly in enqueue order. Multiple pending writes to the same register are all issued; there is no coalescing.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then no valids.
  - Required: REG_write_1=0, WB_count=0, WB_ready=1, LK_hit_1/2=0 throughout.
- Single ALU write:
  - Stimulus: ALU_valid, addr=5, data=0xDEADBEEF at edge N.
  - Required: WB_count=1 after N. After N+1: REG_write_1=1, REG_address_wr=5, REG_data_wb_in1=0xDEADBEEF, WB_count=0. After N+2: REG_write_1=0.
- Dual push ordering:
  - Stimulus: same cycle MEM(addr=3, data=0x11) and ALU(addr=4, data=0x22).
  - Required: output shows addr 3 / 0x11 in the first cycle, then addr 4 / 0x22 in the next; WB_count sequence 2, 1, 0.
- Bypass youngest wins:
  - Stimulus: enqueue addr=7 data=0xA, then next cycle addr=7 data=0xB; then set LK_addr_1=7, LK_addr_2=0.
  - Required: LK_hit_1=1, LK_data_1=0xB, LK_hit_2=0.
  - After the 0xB write drains: LK_hit_1=0.
- Full/overflow:
  - Stimulus: with DEPTH=4, push 2 requests per cycle for 2 cycles, then push a 3rd pair.
  - Required: WB_ready drops once count reaches 3, and WB_count never exceeds 4. The 3rd pair is dropped, and WB_overflow=1 until rst.
- Zero register and reset mid-drain:
  - Stimulus: ALU addr=0 request, then assert rst while count=2.
  - Required: the addr=0 request causes no push and no overflow. After the rst edge: WB_count=0, REG_write_1=0, and no further writes are issued.
